imem_dmem_responder: RTL and testbench
======================================

# imem_dmem_responder

Memory-side responder for the CPU's split instruction and data memory interfaces. It accepts fetch requests on the `pc`/`imem_read` port and load/store requests on the `mem_*` port, holds each for a programmable latency, then returns data with a single-cycle `*_resp` pulse. Both ports share one unified word array, so stores are visible to later fetches. It sits opposite the CPU core in the top-level testbench and in FPGA builds.

## Interface
- `ADDR_WIDTH`, default 10: log2 of the number of 32-bit words (default 1024 words, 4 KiB).
- `IMEM_LATENCY`, default 2: cycles from request acceptance to `imem_resp`. Legal range 1..15.
- `DMEM_LATENCY`, default 3: cycles from request acceptance to `mem_resp`. Legal range 1..15.
- `INIT_FILE`, default "": hex image loaded into the array at elaboration. Empty means no preload.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc` in 32: fetch byte address.
- `imem_read` in 1: fetch request, held high by the CPU until `imem_resp`.
- `instr` out 32: fetched word.
- `imem_resp` out 1: fetch complete, one-cycle pulse.
- `mem_address` in 32: data byte address.
- `mem_wdata` in 32: store data.
- `mem_read` in 1: load request, held until `mem_resp`.
- `mem_write` in 1: store request, held until `mem_resp`.
- `mem_byte_enable` in 4: store lane mask. Bit i enables bits [8i+7:8i].
- `mem_rdata` out 32: load data.
- `mem_resp` out 1: data access complete, one-cycle pulse.
- `proto_err` out 1: sticky protocol-violation flag.

## Operation
- Word index is `addr[ADDR_WIDTH+1:2]`. Bits [1:0] are ignored. Bits above the index alias (wrap-around), with no error.
- Each port has an independent FSM with states IDLE, BUSY, and RESP.
- **IDLE:** if the request is high, latch the address, write data, byte enable, and operation, load the counter with LATENCY-1, and go to BUSY. If LATENCY = 1, go directly to RESP.
- **BUSY:** decrement the counter. At 0, go to RESP.
  - Inputs are not re-sampled while in BUSY; the latched values are used.
  - If the request drops while in BUSY, abort: set `proto_err`, return to IDLE, commit no write, and emit no resp.
- **RESP:**
  - Assert `*_resp` for one cycle.
  - A load drives `mem_rdata`, and a fetch drives `instr`, with the array word at the latched index.
  - A store commits only the enabled bytes at the rising edge ending RESP.
  - The next state is always IDLE.
- A store with `mem_byte_enable` = 0 completes normally (resp pulses) and changes nothing.
- `mem_read` and `mem_write` both high at acceptance:
  - Set `proto_err` and treat the request as a store.
  - `mem_rdata` is unchanged.
- Same-cycle collision: fetch RESP and store RESP to the same word. `instr` returns the pre-store value, and the store commits at that edge.
- Data load RESP in the same cycle as a store commit cannot occur, because there is one data FSM.
- `instr` and `mem_rdata` update only in RESP cycles and hold their value otherwise.
- `proto_err` clears only on `rst`.

## Timing
- Reset values:
  - `instr` = 0, `mem_rdata` = 0.
  - `imem_resp` = 0, `mem_resp` = 0, `proto_err` = 0.
  - Both FSMs in IDLE.
  - Array contents are not reset.
- Request high in the cycle ending at edge t (accepted at t) gives resp high in cycle t+LATENCY-1 → t+LATENCY, so resp is observed LATENCY cycles after acceptance.
- Data outputs are valid in the same cycle as resp.
- Back-to-back: a request still high in the cycle after RESP is a new request (the FSM is back in IDLE). Minimum spacing between resp pulses is LATENCY+1 cycles.
- The two ports run fully concurrently. Neither stalls the other.
- `rst` asserted mid-transaction:
  - Aborts both FSMs at that edge.
  - No pending store commits.
  - No resp is issued.

## Test plan
- **Load after store:** with defaults, store 0xDEADBEEF at 0x100 with be=0xF, then load 0x100. `mem_resp` pulses 3 cycles after each acceptance, and `mem_rdata` = 0xDEADBEEF.
- **Byte lanes and aliasing:**
  - Preload word 0x40 = 0x11223344. Store 0xAABBCCDD with be=0x5. Load returns 0x11BB33DD.
  - A load at 0x40+4096 returns the same value.
- **Fetch/store collision:**
  - Word at 0x20 = 0x00000013. Issue a store of 0x12345678 to 0x20 and a fetch of pc=0x20 so both RESP cycles coincide (IMEM_LATENCY=3, DMEM_LATENCY=3, same accept cycle).
  - `instr` = 0x00000013. A refetch returns 0x12345678.
- **Concurrent ports:** hold `imem_read` and `mem_read` continuously. `imem_resp` pulses every 3 cycles and `mem_resp` every 4 cycles, with no lost or duplicated pulses over 50 cycles.
- **Protocol errors:**
  - Drop `mem_read` one cycle after acceptance: no `mem_resp`, and `proto_err` = 1 and stays 1.
  - Separately, assert read and write together: the store commits and `proto_err` = 1.
- **Reset mid-store:** assert `rst` one cycle before the store's RESP. No resp and no commit (a later load returns the old value). All outputs are 0 the cycle after reset.

Source files
------------

// File: rtl/imem_dmem_responder.sv
// imem_dmem_responder: unified-memory responder for split fetch and load/store ports with programmable latency
module imem_dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int IMEM_LATENCY = 2,
  parameter int DMEM_LATENCY = 3,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        imem_read,
  output logic [31:0] instr,
  output logic        imem_resp,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        proto_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [3:0] I_LAT = 4'(IMEM_LATENCY - 1);
  localparam logic [3:0] D_LAT = 4'(DMEM_LATENCY - 1);
  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
  state_t i_state, d_state;
  logic [3:0] i_cnt, d_cnt, d_be;
  logic [ADDR_WIDTH-1:0] i_idx, d_idx, pc_idx, ma_idx;
  logic [31:0] d_wdata;
  logic d_we, d_req, i_abort, d_abort, unused_bits;
  assign pc_idx = pc[ADDR_WIDTH+1:2];
  assign ma_idx = mem_address[ADDR_WIDTH+1:2];
  assign d_req = mem_read | mem_write;
  assign i_abort = i_state == BUSY && !imem_read;
  assign d_abort = d_state == BUSY && !d_req;
  assign unused_bits = ^{pc[31:ADDR_WIDTH+2], pc[1:0], mem_address[31:ADDR_WIDTH+2], mem_address[1:0]};
  always_ff @(posedge clk) begin
    if (rst) begin
      i_state <= IDLE;
      instr <= '0;
      imem_resp <= 1'b0;
    end else begin
      imem_resp <= 1'b0;
      case (i_state)
        IDLE: if (imem_read) begin
          i_idx <= pc_idx;
          i_cnt <= I_LAT;
          i_state <= I_LAT == 4'd0 ? RESP : BUSY;
          if (I_LAT == 4'd0) begin
            imem_resp <= 1'b1;
            instr <= mem[pc_idx];
          end
        end
        BUSY: begin
          i_cnt <= i_cnt - 4'd1;
          if (i_abort) i_state <= IDLE;
          else if (i_cnt == 4'd1) begin
            i_state <= RESP;
            imem_resp <= 1'b1;
            instr <= mem[i_idx];
          end
        end
        default: i_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      d_state <= IDLE;
      mem_rdata <= '0;
      mem_resp <= 1'b0;
    end else begin
      mem_resp <= 1'b0;
      case (d_state)
        IDLE: if (d_req) begin
          d_idx <= ma_idx;
          d_wdata <= mem_wdata;
          d_be <= mem_byte_enable;
          d_we <= mem_write;
          d_cnt <= D_LAT;
          d_state <= D_LAT == 4'd0 ? RESP : BUSY;
          if (D_LAT == 4'd0) begin
            mem_resp <= 1'b1;
            if (!mem_write) mem_rdata <= mem[ma_idx];
          end
        end
        BUSY: begin
          d_cnt <= d_cnt - 4'd1;
          if (d_abort) d_state <= IDLE;
          else if (d_cnt == 4'd1) begin
            d_state <= RESP;
            mem_resp <= 1'b1;
            if (!d_we) mem_rdata <= mem[d_idx];
          end
        end
        default: d_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (!rst && d_state == RESP && d_we)
      for (int b = 0; b < 4; b++)
        if (d_be[b]) mem[d_idx][8*b +: 8] <= d_wdata[8*b +: 8];
  always_ff @(posedge clk)
    proto_err <= !rst && (proto_err || i_abort || d_abort || (d_state == IDLE && mem_read && mem_write));
endmodule

// File: tb/tb_imem_dmem_responder.sv
// tb_imem_dmem_responder: directed self-checking bench for imem_dmem_responder with default latencies
module tb_imem_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] pc = '0, mem_address = '0, mem_wdata = '0, instr, mem_rdata;
  logic imem_read = 1'b0, mem_read = 1'b0, mem_write = 1'b0, imem_resp, mem_resp, proto_err;
  logic [3:0] mem_byte_enable = '0;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  imem_dmem_responder dut (
    .clk(clk), .rst(rst), .pc(pc), .imem_read(imem_read), .instr(instr), .imem_resp(imem_resp),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_rdata(mem_rdata), .mem_resp(mem_resp), .proto_err(proto_err)
  );
  task automatic data_op(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, output int lat, output logic [31:0] q);
    mem_read = rd;
    mem_write = wr;
    mem_address = addr;
    mem_wdata = wd;
    mem_byte_enable = be;
    lat = -1;
    q = 'x;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_resp) begin
        lat = c;
        q = mem_rdata;
      end
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
  endtask
  task automatic fetch(input logic [31:0] addr, output int lat, output logic [31:0] q);
    imem_read = 1'b1;
    pc = addr;
    lat = -1;
    q = 'x;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (imem_resp) begin
        lat = c;
        q = instr;
      end
    end
    imem_read = 1'b0;
    @(negedge clk);
  endtask
  task automatic apply_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({instr, mem_rdata, imem_resp, mem_resp, proto_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got instr=%h rdata=%h iresp=%b dresp=%b err=%b want all 0", instr, mem_rdata, imem_resp, mem_resp, proto_err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_load_after_store;
    int lat;
    logic [31:0] q;
    data_op(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, lat, q);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL store_latency got %0d want 3", lat); end
    data_op(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, lat, q);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL load_latency got %0d want 3", lat); end
    vectors++;
    if (q !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_after_store got %h want deadbeef", q); end
  endtask
  task automatic test_byte_lanes;
    int lat;
    logic [31:0] q;
    data_op(1'b0, 1'b1, 32'h40, 32'h11223344, 4'hF, lat, q);
    data_op(1'b0, 1'b1, 32'h40, 32'hAABBCCDD, 4'h5, lat, q);
    data_op(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, q);
    vectors++;
    if (q !== 32'h11BB33DD) begin miscompares++; $display("FAIL byte_lanes got %h want 11bb33dd", q); end
    data_op(1'b1, 1'b0, 32'h1040, 32'h0, 4'h0, lat, q);
    vectors++;
    if (q !== 32'h11BB33DD) begin miscompares++; $display("FAIL alias_high got %h want 11bb33dd", q); end
    data_op(1'b1, 1'b0, 32'h43, 32'h0, 4'h0, lat, q);
    vectors++;
    if (q !== 32'h11BB33DD) begin miscompares++; $display("FAIL low_bits_ignored got %h want 11bb33dd", q); end
    data_op(1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'h0, lat, q);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL be0_latency got %0d want 3", lat); end
    vectors++;
    if (mem_rdata !== 32'h11BB33DD) begin miscompares++; $display("FAIL rdata_hold got %h want 11bb33dd", mem_rdata); end
    data_op(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, q);
    vectors++;
    if (q !== 32'h11BB33DD) begin miscompares++; $display("FAIL be0_no_change got %h want 11bb33dd", q); end
  endtask
  task automatic test_fetch;
    int lat;
    logic [31:0] q;
    fetch(32'h100, lat, q);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL fetch_latency got %0d want 2", lat); end
    vectors++;
    if (q !== 32'hDEADBEEF) begin miscompares++; $display("FAIL fetch_data got %h want deadbeef", q); end
    fetch(32'h1100, lat, q);
    vectors++;
    if (q !== 32'hDEADBEEF) begin miscompares++; $display("FAIL fetch_alias got %h want deadbeef", q); end
  endtask
  task automatic test_collision;
    int lat;
    logic [31:0] q;
    data_op(1'b0, 1'b1, 32'h20, 32'h00000013, 4'hF, lat, q);
    mem_write = 1'b1;
    mem_address = 32'h20;
    mem_wdata = 32'h12345678;
    mem_byte_enable = 4'hF;
    @(negedge clk);
    imem_read = 1'b1;
    pc = 32'h20;
    @(negedge clk);
    vectors++;
    if ({imem_resp, mem_resp} !== 2'b00) begin miscompares++; $display("FAIL collision_early got %b want 00", {imem_resp, mem_resp}); end
    @(negedge clk);
    vectors++;
    if ({imem_resp, mem_resp} !== 2'b11) begin miscompares++; $display("FAIL collision_resp got %b want 11", {imem_resp, mem_resp}); end
    vectors++;
    if (instr !== 32'h00000013) begin miscompares++; $display("FAIL collision_instr got %h want 00000013", instr); end
    imem_read = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    fetch(32'h20, lat, q);
    vectors++;
    if (q !== 32'h12345678) begin miscompares++; $display("FAIL refetch got %h want 12345678", q); end
  endtask
  task automatic test_concurrent;
    int ni, nd, bad;
    ni = 0;
    nd = 0;
    bad = 0;
    pc = 32'h100;
    mem_address = 32'h20;
    imem_read = 1'b1;
    mem_read = 1'b1;
    for (int k = 1; k <= 59; k++) begin
      @(negedge clk);
      ni += int'(imem_resp);
      nd += int'(mem_resp);
      if (imem_resp !== (k % 3 == 2) || mem_resp !== (k % 4 == 3)) bad++;
    end
    imem_read = 1'b0;
    mem_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (ni !== 20) begin miscompares++; $display("FAIL concurrent_imem_pulses got %0d want 20", ni); end
    vectors++;
    if (nd !== 15) begin miscompares++; $display("FAIL concurrent_dmem_pulses got %0d want 15", nd); end
    vectors++;
    if (bad !== 0) begin miscompares++; $display("FAIL concurrent_timing got %0d bad cycles want 0", bad); end
    vectors++;
    if ({instr, mem_rdata} !== {32'hDEADBEEF, 32'h12345678}) begin
      miscompares++;
      $display("FAIL concurrent_data got %h %h want deadbeef 12345678", instr, mem_rdata);
    end
    vectors++;
    if (proto_err !== 1'b0) begin miscompares++; $display("FAIL concurrent_err got %b want 0", proto_err); end
  endtask
  task automatic test_proto_abort;
    int n, lat;
    logic [31:0] q;
    apply_reset();
    imem_read = 1'b1;
    pc = 32'h0;
    @(negedge clk);
    imem_read = 1'b0;
    n = 0;
    repeat (4) begin @(negedge clk); n += int'(imem_resp); end
    vectors++;
    if (n !== 0) begin miscompares++; $display("FAIL fetch_abort_resp got %0d pulses want 0", n); end
    vectors++;
    if (proto_err !== 1'b1) begin miscompares++; $display("FAIL fetch_abort_err got %b want 1", proto_err); end
    apply_reset();
    vectors++;
    if (proto_err !== 1'b0) begin miscompares++; $display("FAIL err_cleared got %b want 0", proto_err); end
    mem_read = 1'b1;
    mem_address = 32'h100;
    @(negedge clk);
    mem_read = 1'b0;
    n = 0;
    repeat (4) begin @(negedge clk); n += int'(mem_resp); end
    vectors++;
    if (n !== 0) begin miscompares++; $display("FAIL load_abort_resp got %0d pulses want 0", n); end
    vectors++;
    if (proto_err !== 1'b1) begin miscompares++; $display("FAIL load_abort_err got %b want 1", proto_err); end
    data_op(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, lat, q);
    vectors++;
    if ({q, proto_err} !== {32'hDEADBEEF, 1'b1}) begin miscompares++; $display("FAIL err_sticky got %h %b want deadbeef 1", q, proto_err); end
  endtask
  task automatic test_rw_both;
    int lat;
    logic [31:0] q;
    apply_reset();
    data_op(1'b1, 1'b1, 32'h300, 32'hCAFEF00D, 4'hF, lat, q);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL rw_latency got %0d want 3", lat); end
    vectors++;
    if (q !== 32'h0) begin miscompares++; $display("FAIL rw_rdata_unchanged got %h want 00000000", q); end
    vectors++;
    if (proto_err !== 1'b1) begin miscompares++; $display("FAIL rw_err got %b want 1", proto_err); end
    data_op(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, lat, q);
    vectors++;
    if (q !== 32'hCAFEF00D) begin miscompares++; $display("FAIL rw_store_commit got %h want cafef00d", q); end
  endtask
  task automatic test_reset_mid_store;
    int lat;
    logic [31:0] q;
    data_op(1'b0, 1'b1, 32'h200, 32'h55AA55AA, 4'hF, lat, q);
    data_op(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, lat, q);
    fetch(32'h100, lat, q);
    mem_write = 1'b1;
    mem_address = 32'h200;
    mem_wdata = 32'hFFFFFFFF;
    mem_byte_enable = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mem_write = 1'b0;
    @(negedge clk);
    vectors++;
    if ({instr, mem_rdata, imem_resp, mem_resp, proto_err} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs got instr=%h rdata=%h iresp=%b dresp=%b err=%b want all 0", instr, mem_rdata, imem_resp, mem_resp, proto_err);
    end
    rst = 1'b0;
    @(negedge clk);
    data_op(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, lat, q);
    vectors++;
    if (q !== 32'h55AA55AA) begin miscompares++; $display("FAIL mid_reset_no_commit got %h want 55aa55aa", q); end
  endtask
  initial begin
    test_reset();
    test_load_after_store();
    test_byte_lanes();
    test_fetch();
    test_collision();
    test_concurrent();
    test_proto_abort();
    test_rw_both();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
